// File: rtl/count_pkg.sv
// Shared types and wrap rule for the counter and its sequence checker.
// cnt_next is the single definition of "next value" for both sides.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_MAX_W     = 64;

  typedef logic [CNT_MAX_W-1:0] cnt_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);

  // m == 0 selects a plain power-of-two wrap.
  function automatic cnt_t cnt_next(
    input cnt_t x,
    input cnt_t m
  );
    if (m != '0 && x == m - CNT_ONE)
      return '0;
    return x + CNT_ONE;
  endfunction

endpackage

// File: rtl/count_next_calc.sv
// Combinational next-value helper built on count_pkg::cnt_next.
// Inputs are zero-extended, so truncation yields the 2^WIDTH wrap.
module count_next_calc
  import count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] y
);

  cnt_t r;

  assign r = cnt_next(cnt_t'(x), cnt_t'(m));
  assign y = r[WIDTH-1:0];

  generate
    if (WIDTH < CNT_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^r[CNT_MAX_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/count_seq_checker.sv
// Checks a counter stream for a legal incrementing/wrapping sequence.
// Seeds, locks after RELOCK_N matches, and counts errors while locked.
module count_seq_checker
  import count_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int ERR_W    = 16,
  parameter int RELOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic             range_err,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] sample_count
);

  localparam logic [7:0]       RELOCK_V = 8'(RELOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [7:0]       good_run;
  logic [WIDTH-1:0] seed_next;
  logic [WIDTH-1:0] exp_next;
  logic             out_rng;
  logic             hit;

  // Seeding always uses the incoming modulus, advancing the latched one.
  count_next_calc #(.WIDTH(WIDTH)) u_seed (
    .x (count_in),
    .m (m_in),
    .y (seed_next)
  );

  count_next_calc #(.WIDTH(WIDTH)) u_adv (
    .x (expected),
    .m (m_reg),
    .y (exp_next)
  );

  assign out_rng = (m_in != '0) && (count_in >= m_in);
  assign hit     = (count_in == expected);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      locked       <= 1'b0;
      expected     <= '0;
      err_pulse    <= 1'b0;
      range_err    <= 1'b0;
      err_count    <= '0;
      sample_count <= '0;
      good_run     <= '0;
      m_reg        <= '0;
    end else begin
      err_pulse <= 1'b0;
      range_err <= 1'b0;
      if (in_valid) begin
        sample_count <= sample_count + W_ONE;
        unique case (state)
          IDLE: begin
            m_reg <= m_in;
            if (out_rng) begin
              range_err <= 1'b1;
            end else begin
              expected <= seed_next;
              good_run <= '0;
              state    <= SYNC;
            end
          end
          SYNC: begin
            if (hit) begin
              expected <= exp_next;
              good_run <= good_run + 8'd1;
              if (good_run + 8'd1 == RELOCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              m_reg    <= m_in;
              good_run <= '0;
              if (out_rng) begin
                range_err <= 1'b1;
                state     <= IDLE;
              end else begin
                expected <= seed_next;
              end
            end
          end
          LOCKED: begin
            if (hit) begin
              expected <= exp_next;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != ERR_MAX)
                err_count <= err_count + ERR_ONE;
              locked   <= 1'b0;
              good_run <= '0;
              m_reg    <= m_in;
              if (out_rng) begin
                range_err <= 1'b1;
                state     <= IDLE;
              end else begin
                expected <= seed_next;
                state    <= SYNC;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
